// File: rtl/prim_arbiter_rr_reg_if.sv
// Request/grant and output-slot bundle for the registered round-robin arbiter.
// The arbiter uses the slave modport; requesters plus consumer use the master modport.
interface prim_arbiter_rr_reg_if #(
  parameter int N  = 4,
  parameter int DW = 32,
  localparam int IdxW = $clog2(N)
);
  // Slot handshake: a transfer happens on a rising edge where valid_o & ready_i.
  // valid_o never drops before that edge; idx_o/data_o are held stable while
  // valid_o & ~ready_i. A requester holds req_i until its gnt_o bit is seen.
  logic [N-1:0]         req_i;
  logic [N-1:0][DW-1:0] data_i;
  logic [N-1:0]         gnt_o;
  logic                 valid_o;
  logic                 ready_i;
  logic [IdxW-1:0]      idx_o;
  logic [DW-1:0]        data_o;

  modport slave (
    input  req_i, data_i, ready_i,
    output gnt_o, valid_o, idx_o, data_o
  );

  modport master (
    output req_i, data_i, ready_i,
    input  gnt_o, valid_o, idx_o, data_o
  );
endinterface

// File: rtl/prim_arbiter_rr_reg.sv
// N:1 round-robin arbiter feeding a single registered output slot.
// Priority rotates past each winner; the slot reloads in the same cycle it drains.
module prim_arbiter_rr_reg #(
  parameter int N          = 4,
  parameter int DW         = 32,
  parameter int EnDataPort = 1,
  localparam int IdxW      = $clog2(N)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  prim_arbiter_rr_reg_if.slave bus,
  output logic [0:0]          state_dbg_o
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam logic [IdxW:0]   NumPorts = (IdxW+1)'(N);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(N-1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [2*N-1:0]  req_dbl;
  logic [2*N-1:0]  req_rot;
  logic [IdxW-1:0] offset;
  logic [IdxW:0]   win_sum;
  logic [IdxW-1:0] winner;
  logic            any_req;
  logic            load;

  // Rotate requests so bit 0 is the port at ptr, then take the lowest set bit.
  always_comb begin
    req_dbl = {bus.req_i, bus.req_i};
    req_rot = req_dbl >> ptr_q;
    offset  = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req_rot[j]) offset = IdxW'(j);
    end
    win_sum = {1'b0, ptr_q} + {1'b0, offset};
    if (win_sum >= NumPorts) win_sum = win_sum - NumPorts;
    winner = win_sum[IdxW-1:0];
  end

  // Reset masks the load so no grant is ever issued while rst_i is high.
  assign any_req = |bus.req_i;
  assign load    = ~rst_i & any_req & ((state_q == ST_EMPTY) | bus.ready_i);

  always_comb begin
    bus.gnt_o = '0;
    if (load) bus.gnt_o = {{(N-1){1'b0}}, 1'b1} << winner;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (load) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (load)              state_d = ST_FULL;
        else if (bus.ready_i)  state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (load) begin
      idx_d = winner;
      ptr_d = (winner == LastIdx) ? '0 : winner + IdxW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.valid_o = (state_q == ST_FULL);
  assign bus.idx_o   = idx_q;
  assign state_dbg_o = state_q;

  generate
    if (EnDataPort != 0) begin : g_data
      logic [DW-1:0] data_q, data_d;

      always_comb begin
        data_d = data_q;
        if (load) data_d = bus.data_i[winner];
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) data_q <= '0;
        else       data_q <= data_d;
      end

      assign bus.data_o = data_q;
    end else begin : g_no_data
      assign bus.data_o = '0;
    end
  endgenerate

  a_gnt_onehot0 : assert property (@(posedge clk_i) $onehot0(bus.gnt_o));

  a_gnt_subset : assert property (@(posedge clk_i) (bus.gnt_o & ~bus.req_i) == '0);

  a_slot_hold : assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.valid_o & ~bus.ready_i) |=> ($stable(bus.idx_o) && $stable(bus.data_o)));

endmodule

// File: tb/tb_prim_arbiter_rr_reg.sv
// Directed bench for the registered round-robin arbiter (N=4, DW=8).
// Inputs change 1 time unit after a rising edge; gnt_o is checked mid-cycle.
module tb_prim_arbiter_rr_reg;
  localparam int N  = 4;
  localparam int DW = 8;

  logic       clk;
  logic       rst;
  logic [0:0] state_dbg;
  int         total;
  int         bad;

  prim_arbiter_rr_reg_if #(.N(N), .DW(DW)) bus ();

  prim_arbiter_rr_reg #(.N(N), .DW(DW), .EnDataPort(1)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus.slave),
    .state_dbg_o (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the registered slot right after an edge.
  task automatic chk_slot(input string tag, input logic v, input logic [1:0] i, input logic [7:0] d);
    chk({tag, "_valid"}, 32'(bus.valid_o), 32'(v));
    chk({tag, "_idx"},   32'(bus.idx_o),   32'(i));
    chk({tag, "_data"},  32'(bus.data_o),  32'(d));
  endtask

  task automatic chk_gnt(input string tag, input logic [3:0] g);
    #3;
    chk(tag, 32'(bus.gnt_o), 32'(g));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.req_i   = 4'hF;
    bus.ready_i = 1'b1;
    for (int k = 0; k < N; k++) bus.data_i[k] = 8'(8'h10 + k);

    // 1. reset with every port requesting
    #1;
    chk_gnt("rst_gnt_c0", 4'h0);
    tick();
    chk_gnt("rst_gnt_c1", 4'h0);
    tick();
    rst = 1'b0;
    bus.req_i = 4'h0;
    chk_slot("rst_out", 1'b0, 2'd0, 8'h00);
    chk("rst_state", 32'(state_dbg), 32'd0);

    // 2. all ports requesting, consumer always ready
    bus.req_i = 4'hF;
    for (int c = 0; c < 5; c++) begin
      chk_gnt($sformatf("rr_gnt_%0d", c), 4'(1 << (c % 4)));
      tick();
      chk_slot($sformatf("rr_slot_%0d", c), 1'b1, 2'(c % 4), 8'(8'h10 + (c % 4)));
    end

    // 3. single requester granted once, then slot stalls five cycles
    bus.req_i   = 4'b0100;
    bus.ready_i = 1'b1;
    chk_gnt("stall_gnt", 4'b0100);
    tick();
    bus.req_i   = 4'b0000;
    bus.ready_i = 1'b0;
    chk_slot("stall_load", 1'b1, 2'd2, 8'h12);
    for (int c = 0; c < 5; c++) begin
      chk_gnt($sformatf("stall_nogrant_%0d", c), 4'b0000);
      tick();
      chk_slot($sformatf("stall_hold_%0d", c), 1'b1, 2'd2, 8'h12);
    end
    bus.ready_i = 1'b1;
    tick();
    chk("stall_drain_valid", 32'(bus.valid_o), 32'd0);
    chk("stall_drain_state", 32'(state_dbg), 32'd0);

    // 4. wrap: grant port 3, then ports 0 and 3 compete
    bus.req_i = 4'b1000;
    chk_gnt("wrap_gnt3", 4'b1000);
    tick();
    chk_slot("wrap_slot3", 1'b1, 2'd3, 8'h13);
    bus.req_i = 4'b1001;
    chk_gnt("wrap_gnt0", 4'b0001);
    tick();
    chk_slot("wrap_slot0", 1'b1, 2'd0, 8'h10);
    chk_gnt("wrap_gnt3b", 4'b1000);
    tick();
    chk_slot("wrap_slot3b", 1'b1, 2'd3, 8'h13);

    // 5. drain and reload on the same edge; port 1 data updated while waiting
    bus.req_i     = 4'b0010;
    bus.data_i[1] = 8'hA5;
    chk_gnt("b2b_gnt", 4'b0010);
    tick();
    chk_slot("b2b_slot", 1'b1, 2'd1, 8'hA5);

    // deasserted request is never granted
    bus.req_i   = 4'b0000;
    bus.ready_i = 1'b0;
    chk_gnt("drop_req_gnt", 4'b0000);
    tick();
    chk_slot("drop_req_hold", 1'b1, 2'd1, 8'hA5);

    // 6. reset while the slot holds port 3 and the consumer stalls
    bus.ready_i = 1'b1;
    bus.req_i   = 4'b1000;
    chk_gnt("mid_gnt3", 4'b1000);
    tick();
    chk_slot("mid_slot3", 1'b1, 2'd3, 8'h13);
    bus.req_i   = 4'hF;
    bus.ready_i = 1'b0;
    rst         = 1'b1;
    chk_gnt("mid_rst_gnt", 4'b0000);
    tick();
    rst         = 1'b0;
    bus.ready_i = 1'b1;
    chk_slot("mid_rst_out", 1'b0, 2'd0, 8'h00);
    chk_gnt("mid_first_gnt", 4'b0001);
    tick();
    chk_slot("mid_first_slot", 1'b1, 2'd0, 8'h10);
    chk_gnt("mid_second_gnt", 4'b0010);
    tick();
    chk_slot("mid_second_slot", 1'b1, 2'd1, 8'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
